gslcd_v2_0_timing: RTL and testbench

GSLCD_V2_0_TIMING -- requirements
Module: gslcd_v2_0_timing

---
 rtl/gslcd_v2_0_timing.sv | 179 +++++++++++++++++
 tb/tb_gslcd_v2_0_timing.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/gslcd_v2_0_timing.sv
// LCD panel timing generator: sync, data-enable and pixel-fetch strobes
// derived from free-running pixel/line counters. The counters run against
// shadowed timing registers that reload only at the frame boundary.
module gslcd_v2_0_timing #(
  parameter int C_LINE_WIDTH  = 10,
  parameter int C_PIXEL_WIDTH = 10,
  parameter int C_RD_LEAD     = 1,
  parameter int C_HSYNC_POL   = 1,
  parameter int C_VSYNC_POL   = 1
) (
  input  logic                     pclk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [C_PIXEL_WIDTH-1:0] h_total_i,
  input  logic [C_PIXEL_WIDTH-1:0] h_sync_start_i,
  input  logic [C_PIXEL_WIDTH-1:0] h_sync_end_i,
  input  logic [C_PIXEL_WIDTH-1:0] h_act_start_i,
  input  logic [C_LINE_WIDTH-1:0]  v_total_i,
  input  logic [C_LINE_WIDTH-1:0]  v_sync_start_i,
  input  logic [C_LINE_WIDTH-1:0]  v_sync_end_i,
  input  logic [C_LINE_WIDTH-1:0]  v_act_start_i,
  output logic                     hsync_o,
  output logic                     vsync_o,
  output logic                     active_o,
  output logic                     rd_active_o,
  output logic                     frame_start_o,
  output logic                     line_start_o,
  output logic [C_PIXEL_WIDTH-1:0] pixel_x_o,
  output logic [C_LINE_WIDTH-1:0]  pixel_y_o,
  output logic                     busy_o
);

  // state    | meaning
  // S_IDLE   | stopped; outputs inactive, counters parked at 0
  // S_RUN    | scanning frames continuously
  // S_DRAIN  | run request dropped; finishing the current frame
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam int PW = C_PIXEL_WIDTH;
  localparam int LW = C_LINE_WIDTH;
  localparam logic HS_ON = (C_HSYNC_POL != 0);
  localparam logic VS_ON = (C_VSYNC_POL != 0);

  state_t          state_q, state_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic [LW-1:0]   lin_q, lin_d;
  logic            load;
  logic            pix_last, lin_last, wrap, running;

  logic [PW-1:0]   sh_h_total_q, sh_h_ss_q, sh_h_se_q, sh_h_act_q;
  logic [LW-1:0]   sh_v_total_q, sh_v_ss_q, sh_v_se_q, sh_v_act_q;

  logic            hsync_q, vsync_q, active_q, rd_q, fs_q, ls_q, busy_q;
  logic [PW-1:0]   px_q, px_d;
  logic [LW-1:0]   py_q, py_d;
  logic            hs_hit, vs_hit, act_hit, rd_hit;
  logic [PW:0]     pix_ext, rd_lo, rd_hi;

  assign pix_last = (pix_q == sh_h_total_q - PW'(1));
  assign lin_last = (lin_q == sh_v_total_q - LW'(1));
  assign wrap     = pix_last && lin_last;
  assign running  = (state_q != S_IDLE);

  // Next-state, counter advance and shadow-load decision
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    lin_d   = lin_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        pix_d = '0;
        lin_d = '0;
        if (en_i) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN, S_DRAIN: begin
        if (pix_last) begin
          pix_d = '0;
          lin_d = lin_last ? '0 : lin_q + LW'(1);
        end else begin
          pix_d = pix_q + PW'(1);
        end
        if (en_i) begin
          state_d = S_RUN;
          load    = wrap;
        end else if (wrap) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and timing shadows
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      pix_q        <= '0;
      lin_q        <= '0;
      sh_h_total_q <= '0;
      sh_h_ss_q    <= '0;
      sh_h_se_q    <= '0;
      sh_h_act_q   <= '0;
      sh_v_total_q <= '0;
      sh_v_ss_q    <= '0;
      sh_v_se_q    <= '0;
      sh_v_act_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      lin_q   <= lin_d;
      if (load) begin
        sh_h_total_q <= h_total_i;
        sh_h_ss_q    <= h_sync_start_i;
        sh_h_se_q    <= h_sync_end_i;
        sh_h_act_q   <= h_act_start_i;
        sh_v_total_q <= v_total_i;
        sh_v_ss_q    <= v_sync_start_i;
        sh_v_se_q    <= v_sync_end_i;
        sh_v_act_q   <= v_act_start_i;
      end
    end
  end

  // Output decode from the current counter position; the extra bit on the
  // fetch window keeps the lead subtraction from wrapping.
  always_comb begin
    pix_ext = {1'b0, pix_q};
    rd_lo   = {1'b0, sh_h_act_q} - (PW+1)'(C_RD_LEAD);
    rd_hi   = {1'b0, sh_h_total_q} - (PW+1)'(C_RD_LEAD);
    hs_hit  = (pix_q >= sh_h_ss_q) && (pix_q < sh_h_se_q);
    vs_hit  = (lin_q >= sh_v_ss_q) && (lin_q < sh_v_se_q);
    act_hit = (lin_q >= sh_v_act_q) && (pix_q >= sh_h_act_q);
    rd_hit  = (lin_q >= sh_v_act_q) && (pix_ext >= rd_lo) && (pix_ext < rd_hi);
    px_d    = (running && act_hit) ? pix_q - sh_h_act_q : '0;
    py_d    = (running && act_hit) ? lin_q - sh_v_act_q : '0;
  end

  // Registered outputs
  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      hsync_q  <= ~HS_ON;
      vsync_q  <= ~VS_ON;
      active_q <= 1'b0;
      rd_q     <= 1'b0;
      fs_q     <= 1'b0;
      ls_q     <= 1'b0;
      px_q     <= '0;
      py_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      hsync_q  <= (running && hs_hit) ? HS_ON : ~HS_ON;
      vsync_q  <= (running && vs_hit) ? VS_ON : ~VS_ON;
      active_q <= running && act_hit;
      rd_q     <= running && rd_hit;
      fs_q     <= running && (pix_q == '0) && (lin_q == '0);
      ls_q     <= running && (pix_q == '0);
      px_q     <= px_d;
      py_q     <= py_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign active_o      = active_q;
  assign rd_active_o   = rd_q;
  assign frame_start_o = fs_q;
  assign line_start_o  = ls_q;
  assign pixel_x_o     = px_q;
  assign pixel_y_o     = py_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_gslcd_v2_0_timing.sv
// Directed bench for gslcd_v2_0_timing: a default-parameter instance and a
// second instance with inverted HSYNC and a 3-cycle fetch lead share stimulus.
module tb_gslcd_v2_0_timing;

  logic       pclk = 1'b0;
  logic       rst, en;
  logic [9:0] h_total, h_ss, h_se, h_act;
  logic [9:0] v_total, v_ss, v_se, v_act;

  logic       hs1, vs1, act1, rd1, fs1, ls1, busy1;
  logic [9:0] px1, py1;
  logic       hs2, vs2, act2, rd2, fs2, ls2, busy2;
  logic [9:0] px2, py2;

  int vectors = 0;
  int miscompares = 0;

  always #5 pclk = ~pclk;

  gslcd_v2_0_timing dut1 (
    .pclk_i(pclk), .rst_i(rst), .en_i(en),
    .h_total_i(h_total), .h_sync_start_i(h_ss), .h_sync_end_i(h_se), .h_act_start_i(h_act),
    .v_total_i(v_total), .v_sync_start_i(v_ss), .v_sync_end_i(v_se), .v_act_start_i(v_act),
    .hsync_o(hs1), .vsync_o(vs1), .active_o(act1), .rd_active_o(rd1),
    .frame_start_o(fs1), .line_start_o(ls1), .pixel_x_o(px1), .pixel_y_o(py1),
    .busy_o(busy1)
  );

  gslcd_v2_0_timing #(.C_RD_LEAD(3), .C_HSYNC_POL(0)) dut2 (
    .pclk_i(pclk), .rst_i(rst), .en_i(en),
    .h_total_i(h_total), .h_sync_start_i(h_ss), .h_sync_end_i(h_se), .h_act_start_i(h_act),
    .v_total_i(v_total), .v_sync_start_i(v_ss), .v_sync_end_i(v_se), .v_act_start_i(v_act),
    .hsync_o(hs2), .vsync_o(vs2), .active_o(act2), .rd_active_o(rd2),
    .frame_start_o(fs2), .line_start_o(ls2), .pixel_x_o(px2), .pixel_y_o(py2),
    .busy_o(busy2)
  );

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs len cycles from a FRAME_START sample; optional EN drop/raise and
  // H_TOTAL change points are given as cycle offsets (-1 = none).
  task automatic frame_gap(input string tag, input int len, input int en_off, input int en_on,
                           input int h_chg, input int exp_ls, input int exp_act,
                           input int exp_rd2, input int exp_hs2lo);
    int n_fs = 0, n_ls = 0, n_act = 0, n_rd2 = 0, n_hs2lo = 0, n_idle = 0;
    for (int i = 1; i <= len; i++) begin
      step(1);
      n_fs    += int'(fs1);
      n_ls    += int'(ls1);
      n_act   += int'(act1);
      n_rd2   += int'(rd2);
      n_hs2lo += int'(!hs2);
      n_idle  += int'(!busy1);
      if (i == en_off) en = 1'b0;
      if (i == en_on)  en = 1'b1;
      if (i == h_chg)  h_total = 10'd20;
    end
    chk({tag, "_fs_end"}, fs1, 1);
    chk({tag, "_fs_count"}, n_fs, 1);
    chk({tag, "_ls_count"}, n_ls, exp_ls);
    chk({tag, "_act_count"}, n_act, exp_act);
    chk({tag, "_rd2_count"}, n_rd2, exp_rd2);
    chk({tag, "_hs2_low"}, n_hs2lo, exp_hs2lo);
    chk({tag, "_busy_gap"}, n_idle, 0);
  endtask

  initial begin
    int p, l, n_fs;
    logic e_hs, e_vs, e_act, e_rd, e_rd2;
    logic [9:0] e_px, e_py;
    logic [31:0] obs, exp;

    rst = 1'b1; en = 1'b1;
    h_total = 10'd16; h_ss = 10'd2; h_se = 10'd4; h_act = 10'd6;
    v_total = 10'd8;  v_ss = 10'd1; v_se = 10'd2; v_act = 10'd3;

    // Reset holds IDLE even with EN high
    step(3);
    chk("rst_busy", busy1, 0);
    chk("rst_hsync", hs1, 0);
    chk("rst_vsync", vs1, 0);
    chk("rst_active", act1, 0);
    chk("rst_fs", fs1, 0);
    chk("rst_hsync_pol0", hs2, 1);

    // RUN starts on the first edge after reset release
    rst = 1'b0;
    step(1);
    chk("run_busy", busy1, 1);
    chk("run_fs_early", fs1, 0);
    step(1);

    // First frame, position by position
    for (int t = 0; t < 128; t++) begin
      p = t % 16;
      l = t / 16;
      e_hs  = (p >= 2) && (p < 4);
      e_vs  = (l == 1);
      e_act = (l >= 3) && (p >= 6);
      e_rd  = (l >= 3) && (p >= 5) && (p < 15);
      e_rd2 = (l >= 3) && (p >= 3) && (p < 13);
      e_px  = e_act ? 10'(p - 6) : 10'd0;
      e_py  = e_act ? 10'(l - 3) : 10'd0;
      exp = {3'b0, e_hs, e_vs, e_act, e_rd, (t == 0), (p == 0), !e_hs, e_act, e_rd2, e_px, e_py};
      obs = {3'b0, hs1, vs1, act1, rd1, fs1, ls1, hs2, act2, rd2, px1, py1};
      chk($sformatf("frame1_t%0d", t), obs, exp);
      if (t < 127) step(1);
    end
    step(1);
    chk("frame2_fs", fs1, 1);

    // Drop EN on line 4: frame completes, then IDLE
    step(64);
    en = 1'b0;
    step(62);
    chk("drain_busy_t126", busy1, 1);
    step(1);
    chk("drain_busy_t127", busy1, 0);
    step(1);
    chk("drain_idle_hsync", hs1, 0);
    chk("drain_idle_vsync", vs1, 0);
    chk("drain_idle_hsync_pol0", hs2, 1);
    chk("drain_idle_active", act1, 0);
    n_fs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n_fs += int'(fs1);
    end
    chk("drain_idle_no_fs", n_fs, 0);

    // Restart, then drop EN on line 2 and raise it on line 5: no gap
    en = 1'b1;
    step(2);
    chk("restart_fs", fs1, 1);
    frame_gap("reen", 128, 32, 80, -1, 8, 50, 50, 16);

    // H_TOTAL changed mid-frame takes effect only on the next frame
    frame_gap("hchg_cur", 128, -1, -1, 40, 8, 50, 50, 16);
    frame_gap("hchg_next", 160, -1, -1, -1, 8, 70, 70, 16);

    // Reset mid-line while ACTIVE
    step(70);
    chk("pre_rst_active", act1, 1);
    chk("pre_rst_px", px1, 4);
    chk("pre_rst_py", py1, 0);
    rst = 1'b1;
    step(1);
    chk("post_rst_outs", {hs1, vs1, act1, rd1, fs1, ls1, busy1, hs2}, 8'b0000_0001);
    chk("post_rst_px", px1, 0);
    rst = 1'b0;
    step(1);
    chk("post_rst_run_busy", busy1, 1);
    chk("post_rst_run_fs", fs1, 0);
    step(1);
    chk("post_rst_fs", fs1, 1);
    frame_gap("post_rst", 160, -1, -1, -1, 8, 70, 70, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
